force_wb_ring_node: RTL and testbench

Downstream neighbour of the PE wrapper. It accepts force write-back packets from the PE through a valid/ready handshake and buffers them in a local FIFO. It injects them into free slots of the stall-free unidirectional force ring and forwards transit traffic. Packets addressed to this node's cell are ejected to the local force cache.

---
 rtl/force_wb_ring_node.sv | 131 +++++++++++++
 tb/tb_force_wb_ring_node.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_wb_ring_node.sv
// rtl/force_wb_ring_node.sv - force write-back ring node with local inject FIFO and eject port
//
// Buffers force write-back packets from the PE in a small FIFO, injects them
// into free slots of a stall-free unidirectional ring, forwards transit
// traffic, and ejects packets addressed to this node's cell to the force cache.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pe_wb_in/valid    PE packet {cell_x, cell_y, cell_z, particle_id, fx, fy, fz}
//   pe_ready          FIFO can accept a packet this cycle
//   ring_in/valid     packet and occupancy from the upstream ring node
//   ring_out/valid    registered packet and occupancy to the downstream node
//   local_wb_out/valid registered ejected packet to the force cache
//   fifo_empty        inject FIFO holds no packets
//   inject_count      packets popped from the FIFO, wraps at 2^16
module force_wb_ring_node #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
  parameter int WB_WIDTH          = ID_WIDTH+3*DATA_WIDTH,
  parameter int LOCAL_CELL_X      = 0,
  parameter int LOCAL_CELL_Y      = 0,
  parameter int LOCAL_CELL_Z      = 0,
  parameter int FIFO_DEPTH        = 8,
  parameter int FIFO_ADDR_WIDTH   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_WIDTH-1:0] pe_wb_in,
  input  logic                pe_wb_valid,
  output logic                pe_ready,
  input  logic [WB_WIDTH-1:0] ring_in,
  input  logic                ring_in_valid,
  output logic [WB_WIDTH-1:0] ring_out,
  output logic                ring_out_valid,
  output logic [WB_WIDTH-1:0] local_wb_out,
  output logic                local_wb_valid,
  output logic                fifo_empty,
  output logic [15:0]         inject_count
);

  localparam int CW = CELL_ID_WIDTH;
  localparam logic [CW-1:0] LX = CW'(LOCAL_CELL_X);
  localparam logic [CW-1:0] LY = CW'(LOCAL_CELL_Y);
  localparam logic [CW-1:0] LZ = CW'(LOCAL_CELL_Z);

  function automatic logic is_local(input logic [WB_WIDTH-1:0] pkt);
    return (pkt[WB_WIDTH-1 -: CW] == LX) &&
           (pkt[WB_WIDTH-1-CW -: CW] == LY) &&
           (pkt[WB_WIDTH-1-2*CW -: CW] == LZ);
  endfunction

  // Inject FIFO
  logic [WB_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       full;
  logic                       push, pop;
  logic [WB_WIDTH-1:0]        head;

  assign full       = (count == (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // Gated by rst so the PE sees no ready while the node is held in reset.
  assign pe_ready   = !full && !rst;
  assign push       = pe_wb_valid && pe_ready;
  assign head       = mem[rd_ptr];

  // Slot arbitration: a matching ring packet owns the eject port and frees
  // its ring slot; a non-matching ring packet owns the ring slot.
  logic ring_match, ring_fwd, head_match, pop_eject, pop_inject;

  always_comb begin
    ring_match = ring_in_valid && is_local(ring_in);
    ring_fwd   = ring_in_valid && !is_local(ring_in);
    head_match = !fifo_empty && is_local(head);
    pop_eject  = head_match && !ring_match;
    pop_inject = !fifo_empty && !head_match && !ring_fwd;
    pop        = pop_eject || pop_inject;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pe_wb_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (FIFO_ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output registers: valids reload every cycle, data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_out       <= '0;
      ring_out_valid <= 1'b0;
      local_wb_out   <= '0;
      local_wb_valid <= 1'b0;
      inject_count   <= '0;
    end else begin
      ring_out_valid <= ring_fwd || pop_inject;
      local_wb_valid <= ring_match || pop_eject;
      if (ring_fwd) begin
        ring_out <= ring_in;
      end else if (pop_inject) begin
        ring_out <= head;
      end
      if (ring_match) begin
        local_wb_out <= ring_in;
      end else if (pop_eject) begin
        local_wb_out <= head;
      end
      if (pop) begin
        inject_count <= inject_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_force_wb_ring_node.sv
// tb/tb_force_wb_ring_node.sv - self-checking bench for force_wb_ring_node
module tb_force_wb_ring_node;

  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int PW  = 7;
  localparam int WB  = 3*CW + PW + 3*DW;
  localparam int TAG = 3*DW + PW - 1;  // particle_id MSB: 1 = transit, 0 = PE

  logic          clk = 1'b0;
  logic          rst;
  logic [WB-1:0] pe_wb_in;
  logic          pe_wb_valid;
  logic          pe_ready;
  logic [WB-1:0] ring_in;
  logic          ring_in_valid;
  logic [WB-1:0] ring_out;
  logic          ring_out_valid;
  logic [WB-1:0] local_wb_out;
  logic          local_wb_valid;
  logic          fifo_empty;
  logic [15:0]   inject_count;

  force_wb_ring_node #(
    .LOCAL_CELL_X(1), .LOCAL_CELL_Y(1), .LOCAL_CELL_Z(1)
  ) dut (
    .clk(clk), .rst(rst),
    .pe_wb_in(pe_wb_in), .pe_wb_valid(pe_wb_valid), .pe_ready(pe_ready),
    .ring_in(ring_in), .ring_in_valid(ring_in_valid),
    .ring_out(ring_out), .ring_out_valid(ring_out_valid),
    .local_wb_out(local_wb_out), .local_wb_valid(local_wb_valid),
    .fifo_empty(fifo_empty), .inject_count(inject_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int exp_inject = 0;
  logic [WB-1:0] fq[$];    // FIFO packets in push order
  logic [WB-1:0] tf_q[$];  // transit packets to be forwarded
  logic [WB-1:0] te_q[$];  // transit packets to be ejected

  function automatic logic [WB-1:0] mk(input int x, input int y, input int z,
                                       input bit transit, input int id);
    logic [DW-1:0] fx;
    fx = 32'h3F80_0000 + DW'(id);
    return {CW'(x), CW'(y), CW'(z), transit, 6'(id), fx, fx ^ 32'hA5A5_5A5A, ~fx};
  endfunction

  function automatic bit is_loc(input logic [WB-1:0] p);
    return (p[WB-1 -: CW] == 3'd1) && (p[WB-1-CW -: CW] == 3'd1) &&
           (p[WB-1-2*CW -: CW] == 3'd1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ring(input logic [WB-1:0] p);
    ring_in       = p;
    ring_in_valid = 1'b1;
    if (is_loc(p)) te_q.push_back(p);
    else           tf_q.push_back(p);
  endtask

  task automatic offer_pe(input logic [WB-1:0] p, output bit acc);
    pe_wb_in    = p;
    pe_wb_valid = 1'b1;
    acc         = pe_ready;
    if (acc) begin
      fq.push_back(p);
      exp_inject++;
    end
  endtask

  // Scoreboard monitor: each emitted packet is matched against the queue of
  // its source class; FIFO packets must also leave on the correct port.
  always @(negedge clk) begin
    logic [WB-1:0] e;
    if (mon_en && !rst) begin
      if (local_wb_valid) begin
        n_vec++;
        if (local_wb_out[TAG]) begin
          if (te_q.size() == 0) begin
            n_err++; $display("FAIL local_transit_unexpected got=%h", local_wb_out);
          end else begin
            e = te_q.pop_front();
            if (local_wb_out !== e) begin
              n_err++; $display("FAIL local_transit got=%h exp=%h", local_wb_out, e);
            end
          end
        end else begin
          if (fq.size() == 0) begin
            n_err++; $display("FAIL local_fifo_unexpected got=%h", local_wb_out);
          end else begin
            e = fq.pop_front();
            if (local_wb_out !== e || !is_loc(e)) begin
              n_err++; $display("FAIL local_fifo got=%h exp=%h", local_wb_out, e);
            end
          end
        end
      end
      if (ring_out_valid) begin
        n_vec++;
        if (ring_out[TAG]) begin
          if (tf_q.size() == 0) begin
            n_err++; $display("FAIL ring_transit_unexpected got=%h", ring_out);
          end else begin
            e = tf_q.pop_front();
            if (ring_out !== e) begin
              n_err++; $display("FAIL ring_transit got=%h exp=%h", ring_out, e);
            end
          end
        end else begin
          if (fq.size() == 0) begin
            n_err++; $display("FAIL ring_fifo_unexpected got=%h", ring_out);
          end else begin
            e = fq.pop_front();
            if (ring_out !== e || is_loc(e)) begin
              n_err++; $display("FAIL ring_fifo got=%h exp=%h", ring_out, e);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    bit seen;
    rst = 1'b1; pe_wb_valid = 1'b0; ring_in_valid = 1'b0;
    pe_wb_in = '0; ring_in = '0;
    tick; tick;
    n_vec++;
    if ({fifo_empty, pe_ready, ring_out_valid, local_wb_valid, inject_count, ring_out, local_wb_out}
        !== {4'b1000, 16'd0, {WB{1'b0}}, {WB{1'b0}}}) begin
      n_err++; $display("FAIL reset_state got e=%b r=%b rv=%b lv=%b ic=%0d",
                        fifo_empty, pe_ready, ring_out_valid, local_wb_valid, inject_count);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_vec++;
    if (pe_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got=%b exp=1", pe_ready);
    end
    // Queue 3 packets behind busy transit traffic, then reset mid-run.
    tick;
    ring_in = mk(2, 0, 0, 1, 1); ring_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pe_wb_in = mk(0, 1, 1, 0, i); pe_wb_valid = 1'b1;
      tick;
    end
    pe_wb_valid = 1'b0;
    tick;
    n_vec++;
    if ({fifo_empty, ring_out_valid, inject_count} !== {2'b01, 16'd0}) begin
      n_err++; $display("FAIL reset_prefill got e=%b rv=%b ic=%0d exp e=0 rv=1 ic=0",
                        fifo_empty, ring_out_valid, inject_count);
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({fifo_empty, pe_ready, ring_out_valid, local_wb_valid, inject_count} !== {4'b1000, 16'd0}) begin
      n_err++; $display("FAIL reset_midrun got e=%b r=%b rv=%b lv=%b ic=%0d",
                        fifo_empty, pe_ready, ring_out_valid, local_wb_valid, inject_count);
    end
    tick; tick;
    @(negedge clk); rst = 1'b0; ring_in_valid = 1'b0; #1;
    n_vec++;
    if (pe_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_midrun_ready got=%b exp=1", pe_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (ring_out_valid || local_wb_valid || !fifo_empty) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++; $display("FAIL reset_discard got=activity exp=idle");
    end
    fq.delete(); tf_q.delete(); te_q.delete();
    exp_inject = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_transit;
    logic [WB-1:0] p;
    p = mk(2, 0, 0, 1, 0);
    drive_ring(p);
    tick;
    ring_in_valid = 1'b0;
    n_vec++;
    if ({ring_out_valid, local_wb_valid} !== 2'b10 || ring_out !== p) begin
      n_err++; $display("FAIL transit got rv=%b lv=%b d=%h exp rv=1 lv=0 d=%h",
                        ring_out_valid, local_wb_valid, ring_out, p);
    end
    tick;
    n_vec++;
    if (ring_out_valid !== 1'b0) begin
      n_err++; $display("FAIL transit_clear got=%b exp=0", ring_out_valid);
    end
  endtask

  task automatic test_eject_inject;
    bit acc;
    offer_pe(mk(0, 1, 1, 0, 16), acc);
    tick;
    pe_wb_valid = 1'b0;
    drive_ring(mk(1, 1, 1, 1, 17));
    n_vec++;
    if (!acc || fifo_empty !== 1'b0) begin
      n_err++; $display("FAIL ei_push got acc=%b e=%b exp acc=1 e=0", acc, fifo_empty);
    end
    tick;
    ring_in_valid = 1'b0;
    n_vec++;
    if ({local_wb_valid, ring_out_valid} !== 2'b11 || inject_count !== 16'(exp_inject)) begin
      n_err++; $display("FAIL eject_inject got lv=%b rv=%b ic=%0d exp 1 1 %0d",
                        local_wb_valid, ring_out_valid, inject_count, exp_inject);
    end
    tick;
  endtask

  task automatic test_eject_conflict;
    bit acc;
    offer_pe(mk(1, 1, 1, 0, 20), acc);
    tick;
    pe_wb_valid = 1'b0;
    drive_ring(mk(1, 1, 1, 1, 21));
    tick;
    ring_in_valid = 1'b0;
    n_vec++;
    if ({local_wb_valid, ring_out_valid, local_wb_out[TAG]} !== 3'b101) begin
      n_err++; $display("FAIL conflict_first got lv=%b rv=%b tag=%b exp 1 0 1",
                        local_wb_valid, ring_out_valid, local_wb_out[TAG]);
    end
    tick;
    n_vec++;
    if ({local_wb_valid, ring_out_valid, local_wb_out[TAG], fifo_empty} !== 4'b1001) begin
      n_err++; $display("FAIL conflict_second got lv=%b rv=%b tag=%b e=%b exp 1 0 0 1",
                        local_wb_valid, ring_out_valid, local_wb_out[TAG], fifo_empty);
    end
    tick;
    n_vec++;
    if (inject_count !== 16'(exp_inject)) begin
      n_err++; $display("FAIL conflict_count got=%0d exp=%0d", inject_count, exp_inject);
    end
  endtask

  task automatic test_backpressure;
    bit acc;
    for (int i = 0; i < 9; i++) begin
      drive_ring(mk(3, i % 8, 0, 1, 30 + i));
      offer_pe(mk(0, 0, 2, 0, 40 + i), acc);
      n_vec++;
      if (acc !== (i < 8)) begin
        n_err++; $display("FAIL bp_accept_%0d got=%b exp=%b", i, acc, i < 8);
      end
      tick;
    end
    pe_wb_valid = 1'b0;
    ring_in_valid = 1'b0;
    n_vec++;
    if ({pe_ready, fifo_empty} !== 2'b00) begin
      n_err++; $display("FAIL bp_full got r=%b e=%b exp 0 0", pe_ready, fifo_empty);
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      n_vec++;
      if (ring_out_valid !== 1'b1 || (k == 0 && pe_ready !== 1'b1)) begin
        n_err++; $display("FAIL bp_drain_%0d got rv=%b r=%b exp rv=1 r=1", k, ring_out_valid, pe_ready);
      end
    end
    tick;
    n_vec++;
    if ({ring_out_valid, fifo_empty} !== 2'b01 || inject_count !== 16'(exp_inject)) begin
      n_err++; $display("FAIL bp_done got rv=%b e=%b ic=%0d exp 0 1 %0d",
                        ring_out_valid, fifo_empty, inject_count, exp_inject);
    end
  endtask

  task automatic test_latency;
    bit acc;
    logic [WB-1:0] p;
    p = mk(0, 2, 0, 0, 50);
    offer_pe(p, acc);
    tick;
    pe_wb_valid = 1'b0;
    n_vec++;
    if (!acc || ring_out_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_n1 got acc=%b rv=%b exp 1 0", acc, ring_out_valid);
    end
    tick;
    n_vec++;
    if ({ring_out_valid, fifo_empty} !== 2'b11 || ring_out !== p) begin
      n_err++; $display("FAIL latency_n2 got rv=%b e=%b d=%h exp 1 1 %h",
                        ring_out_valid, fifo_empty, ring_out, p);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    bit acc;
    int sel;
    for (int c = 0; c < 300; c++) begin
      sel = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        drive_ring(sel == 0 ? mk(1, 1, 1, 1, c) : sel == 1 ? mk(2, 0, 0, 1, c) : mk(0, 1, 1, 1, c));
      else
        ring_in_valid = 1'b0;
      sel = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        offer_pe(sel == 0 ? mk(1, 1, 1, 0, c) : sel == 1 ? mk(4, 0, 0, 0, c) : mk(1, 1, 0, 0, c), acc);
      else
        pe_wb_valid = 1'b0;
      tick;
    end
    pe_wb_valid = 1'b0;
    ring_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    n_vec++;
    if (fq.size() != 0 || tf_q.size() != 0 || te_q.size() != 0 || fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL b2b_drain got fq=%0d tf=%0d te=%0d e=%b exp 0 0 0 1",
                        fq.size(), tf_q.size(), te_q.size(), fifo_empty);
    end
    n_vec++;
    if (inject_count !== 16'(exp_inject)) begin
      n_err++; $display("FAIL b2b_count got=%0d exp=%0d", inject_count, exp_inject);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_transit;
    test_eject_inject;
    test_eject_conflict;
    test_backpressure;
    test_latency;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
